// File: rtl/cpu_seq_pkg.sv
// Shared types for the RV32 phase sequencer: phase encoding and wait-timer bounds.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd7
  } phase_t;

  // Ack wait bound range; the timer is sized to hold the largest legal bound.
  localparam int unsigned MEM_TIMEOUT_MAX = 255;
  localparam int unsigned TMR_W           = 8;

endpackage

// File: rtl/seq_wait_timer.sv
// Ack-wait down-counter: clr reloads LIMIT-1, en counts down, expire flags the last allowed wait cycle.
module seq_wait_timer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned LIM_C = (LIMIT > MEM_TIMEOUT_MAX) ? MEM_TIMEOUT_MAX :
                                  (LIMIT == 0)              ? 1 : LIMIT;
  localparam logic [TMR_W-1:0] LOAD = TMR_W'(LIM_C - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/cpu_phase_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with IROM/DRAM handshakes, run/step control and bus timeout.
// Optional perf counters (instret, cycles) are built only when PERF_CNT_EN is defined.
module cpu_phase_seq
  import cpu_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             run,
  input  logic             step_req,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             reg_write_dec,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic             rf_we,
  output logic             retire,
  output logic             halted,
  output logic             bus_err,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycles
);

  phase_t state_q, state_d;
  logic   tmr_clr, tmr_en, tmr_expire;

  // A single step needs no extra state: with run low, WB always falls back to IDLE.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    bus_err  = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        halted = 1'b1;
        if (run || step_req) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        tmr_en   = !imem_ack;
        if (imem_ack)        state_d = DECODE;
        else if (tmr_expire) state_d = ERR;
      end
      DECODE: state_d = EXEC;
      EXEC:   state_d = (is_load || is_store) ? MEM : WB;
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        tmr_en   = !dmem_ack;
        if (dmem_ack)        state_d = WB;
        else if (tmr_expire) state_d = ERR;
      end
      WB: begin
        pc_we   = 1'b1;
        rf_we   = reg_write_dec;
        retire  = 1'b1;
        state_d = run ? FETCH : IDLE;
      end
      ERR:     bus_err = 1'b1;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reload on every phase change so each FETCH/MEM visit gets a fresh wait budget.
  assign tmr_clr = (state_d != state_q);

  seq_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk_i    (cpu_clk),
    .rst_ni   (cpu_rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  assign phase = state_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] instret_q, cycles_q;

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      instret_q <= instret_q + CNT_W'(state_q == WB);
      cycles_q  <= cycles_q + CNT_W'(state_q != IDLE);
    end
  end

  assign instret = instret_q;
  assign cycles  = cycles_q;
`else
  assign instret = '0;
  assign cycles  = '0;
`endif

endmodule

// File: tb/tb_cpu_phase_seq.sv
// Directed vector bench for cpu_phase_seq: per-cycle table plus timeout, last-cycle-ack and async-reset sequences.
module tb_cpu_phase_seq;
  import cpu_seq_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        run, step_req, is_load, is_store, reg_write_dec, imem_ack, dmem_ack;
  logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, retire, halted, bus_err;
  logic [2:0]  phase;
  logic [31:0] instret, cycles;

  int errors = 0;
  int checks = 0;
  int n_wb   = 0;
  int n_act  = 0;

  always #5 cpu_clk = ~cpu_clk;

  cpu_phase_seq #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rst       (cpu_rst),
    .run           (run),
    .step_req      (step_req),
    .is_load       (is_load),
    .is_store      (is_store),
    .reg_write_dec (reg_write_dec),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .ir_we         (ir_we),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ack      (dmem_ack),
    .pc_we         (pc_we),
    .rf_we         (rf_we),
    .retire        (retire),
    .halted        (halted),
    .bus_err       (bus_err),
    .phase         (phase),
    .instret       (instret),
    .cycles        (cycles)
  );

  // Strobe order: imem_req ir_we dmem_req dmem_we pc_we rf_we retire halted bus_err
  localparam logic [8:0] S_IDLE = 9'b000000010;
  localparam logic [8:0] S_F    = 9'b110000000;
  localparam logic [8:0] S_FW   = 9'b100000000;
  localparam logic [8:0] S_0    = 9'b000000000;
  localparam logic [8:0] S_M    = 9'b001000000;
  localparam logic [8:0] S_MW   = 9'b001100000;
  localparam logic [8:0] S_WB   = 9'b000011100;
  localparam logic [8:0] S_WBN  = 9'b000010100;
  localparam logic [8:0] S_ERR  = 9'b000000001;

  // Input order: run step_req is_load is_store reg_write_dec imem_ack dmem_ack
  typedef struct packed {
    logic [6:0] in;
    logic [2:0] ph;
    logic [8:0] str;
  } vec_t;

  localparam int NV = 40;
  vec_t tbl [NV];

  wire [8:0] act_str = {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, retire, halted, bus_err};

  function automatic vec_t mk(input logic [6:0] in, input phase_t ph, input logic [8:0] str);
    vec_t v;
    v.in  = in;
    v.ph  = ph;
    v.str = str;
    return v;
  endfunction

  task automatic drive(input logic [6:0] v);
    {run, step_req, is_load, is_store, reg_write_dec, imem_ack, dmem_ack} = v;
  endtask

  task automatic chk(input string nm, input int idx, input logic [2:0] eph, input logic [8:0] estr);
    checks++;
    if ({phase, act_str} !== {eph, estr}) begin
      errors++;
      $display("FAIL %s[%0d]: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
               nm, idx, phase, act_str, eph, estr);
    end
  endtask

  task automatic chk_cnt(input string nm, input int idx, input int ei, input int ec);
`ifndef PERF_CNT_EN
    ei = 0;
    ec = 0;
`endif
    checks++;
    if (instret !== 32'(ei) || cycles !== 32'(ec)) begin
      errors++;
      $display("FAIL %s[%0d]: got instret=%0d cycles=%0d, expected instret=%0d cycles=%0d",
               nm, idx, instret, cycles, ei, ec);
    end
  endtask

  task automatic do_reset();
    cpu_rst = 1'b0;
    drive(7'b0000000);
    repeat (2) @(negedge cpu_clk);
    cpu_rst = 1'b1;
  endtask

  initial begin
    // non-mem x2, load with 2 ack waits, store, run drop, single step, run+step
    tbl[0]  = mk(7'b0000000, IDLE,   S_IDLE);
    tbl[1]  = mk(7'b1000110, IDLE,   S_IDLE);
    tbl[2]  = mk(7'b1000110, FETCH,  S_F);
    tbl[3]  = mk(7'b1000110, DECODE, S_0);
    tbl[4]  = mk(7'b1000110, EXEC,   S_0);
    tbl[5]  = mk(7'b1000110, WB,     S_WB);
    tbl[6]  = mk(7'b1000110, FETCH,  S_F);
    tbl[7]  = mk(7'b1000110, DECODE, S_0);
    tbl[8]  = mk(7'b1000110, EXEC,   S_0);
    tbl[9]  = mk(7'b1000110, WB,     S_WB);
    tbl[10] = mk(7'b1010110, FETCH,  S_F);
    tbl[11] = mk(7'b1010110, DECODE, S_0);
    tbl[12] = mk(7'b1010110, EXEC,   S_0);
    tbl[13] = mk(7'b1010110, MEM,    S_M);
    tbl[14] = mk(7'b1010110, MEM,    S_M);
    tbl[15] = mk(7'b1010111, MEM,    S_M);
    tbl[16] = mk(7'b1010110, WB,     S_WB);
    tbl[17] = mk(7'b1001011, FETCH,  S_F);
    tbl[18] = mk(7'b1001011, DECODE, S_0);
    tbl[19] = mk(7'b1001011, EXEC,   S_0);
    tbl[20] = mk(7'b1001011, MEM,    S_MW);
    tbl[21] = mk(7'b1001011, WB,     S_WBN);
    tbl[22] = mk(7'b1000110, FETCH,  S_F);
    tbl[23] = mk(7'b1000110, DECODE, S_0);
    tbl[24] = mk(7'b0000110, EXEC,   S_0);
    tbl[25] = mk(7'b0000110, WB,     S_WB);
    tbl[26] = mk(7'b0000110, IDLE,   S_IDLE);
    tbl[27] = mk(7'b0100110, IDLE,   S_IDLE);
    tbl[28] = mk(7'b0000110, FETCH,  S_F);
    tbl[29] = mk(7'b0100110, DECODE, S_0);
    tbl[30] = mk(7'b0000110, EXEC,   S_0);
    tbl[31] = mk(7'b0000110, WB,     S_WB);
    tbl[32] = mk(7'b0000110, IDLE,   S_IDLE);
    tbl[33] = mk(7'b0000110, IDLE,   S_IDLE);
    tbl[34] = mk(7'b1100110, IDLE,   S_IDLE);
    tbl[35] = mk(7'b0000110, FETCH,  S_F);
    tbl[36] = mk(7'b0000110, DECODE, S_0);
    tbl[37] = mk(7'b0000110, EXEC,   S_0);
    tbl[38] = mk(7'b0000110, WB,     S_WB);
    tbl[39] = mk(7'b0000110, IDLE,   S_IDLE);

    cpu_rst = 1'b0;
    drive(7'b0000000);
    #1;
    chk("reset", 0, IDLE, S_IDLE);
    chk_cnt("reset_cnt", 0, 0, 0);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].in);
      #1;
      chk("vec", i, tbl[i].ph, tbl[i].str);
      chk_cnt("vec_cnt", i, n_wb, n_act);
      if (tbl[i].ph == WB)   n_wb++;
      if (tbl[i].ph != IDLE) n_act++;
      @(negedge cpu_clk);
    end

    // fetch timeout: 15 unacked FETCH cycles, then sticky ERR
    do_reset();
    drive(7'b1000000);
    #1 chk("tmo", 0, IDLE, S_IDLE);
    for (int k = 1; k <= 15; k++) begin
      @(negedge cpu_clk);
      #1 chk("tmo", k, FETCH, S_FW);
    end
    @(negedge cpu_clk);
    drive(7'b1000111);
    #1 chk("tmo_err", 0, ERR, S_ERR);
    chk_cnt("tmo_cnt", 0, 0, 15);
    for (int k = 1; k <= 3; k++) begin
      @(negedge cpu_clk);
      #1 chk("tmo_err", k, ERR, S_ERR);
    end
    #1 cpu_rst = 1'b0;
    #1 chk("tmo_rst", 0, IDLE, S_IDLE);
    chk_cnt("tmo_rst_cnt", 0, 0, 0);

    // ack on the last allowed FETCH wait cycle is still accepted
    do_reset();
    drive(7'b1000000);
    repeat (15) @(negedge cpu_clk);
    drive(7'b1000010);
    #1 chk("ack_last", 0, FETCH, S_F);
    @(negedge cpu_clk);
    #1 chk("ack_last", 1, DECODE, S_0);

    // async reset while waiting in MEM
    do_reset();
    drive(7'b1010110);
    repeat (5) @(negedge cpu_clk);
    #1 chk("rst_mem", 0, MEM, S_M);
    chk_cnt("rst_mem_cnt", 0, 0, 4);
    #1 cpu_rst = 1'b0;
    #1 chk("rst_mem", 1, IDLE, S_IDLE);
    chk_cnt("rst_mem_cnt", 1, 0, 0);
    @(posedge cpu_clk);
    #1 chk("rst_mem", 2, IDLE, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
